// File: rtl/pulse_burst_detector.sv
// -----------------------------------------------------------------------------
// pulse_burst_detector
//
// Receive-side companion of the pulse and trigger generators. Samples an
// asynchronous pulse train, drops glitches shorter than MIN_WIDTH, counts the
// accepted pulses of a burst and measures the high width of the last accepted
// pulse. A burst is closed and reported once the line has stayed low long
// enough for the gap counter to reach GAP_TIMEOUT.
//
// Ports
//   clock       : system clock, all logic on posedge
//   reset       : asynchronous, active-low reset
//   on          : detector enable (synchronous to clock)
//   signal      : asynchronous pulse-train input
//   burst_count : accepted pulses in the last completed burst (saturating)
//   last_width  : high width in cycles of the last accepted pulse (saturating)
//   burst_valid : one-cycle strobe, burst_count/last_width/overflow updated
//   busy        : a burst is in progress
//   overflow    : pulse counter saturated during the reported burst
// -----------------------------------------------------------------------------
module pulse_burst_detector #(
  parameter int CNT_W       = 8,
  parameter int WID_W       = 8,
  parameter int GAP_TIMEOUT = 16,  // 2..255
  parameter int MIN_WIDTH   = 2    // 1..2^WID_W-1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             on,
  input  logic             signal,
  output logic [CNT_W-1:0] burst_count,
  output logic [WID_W-1:0] last_width,
  output logic             burst_valid,
  output logic             busy,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [WID_W-1:0] WID_MAX = '1;
  localparam logic [WID_W-1:0] MIN_W   = WID_W'(MIN_WIDTH);
  localparam logic [7:0]       GAP_END = 8'(GAP_TIMEOUT);

  // ---------------------------------------------------------------------------
  // Input path: two-flop synchronizer, one edge-detect flop, arming.
  // ---------------------------------------------------------------------------
  logic       sync_meta;
  logic       s_sync;
  logic       s_prev;
  logic [1:0] fill;   // shifts in ones: fill[1] set once s_sync holds a real sample
  logic       armed;
  logic       rise;
  logic       fall;

  // NOTE: clocked state is written with non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours; blocking here would collapse
  // the synchronizer stages into a single flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      s_sync    <= 1'b0;
      s_prev    <= 1'b0;
      fill      <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sync_meta <= signal;
      s_sync    <= sync_meta;
      s_prev    <= s_sync;
      fill      <= {fill[0], 1'b1};
      // The reset value of s_sync is not a real observation of the line, so
      // arming waits for a genuine low sample. A line held high through reset
      // then never produces an accepted rise.
      if (fill[1] && !s_sync) begin
        armed <= 1'b1;
      end
    end
  end

  assign rise = s_sync & ~s_prev;
  assign fall = ~s_sync & s_prev;

  // ---------------------------------------------------------------------------
  // Burst FSM
  // ---------------------------------------------------------------------------
  state_e           state_q,   state_d;
  logic [WID_W-1:0] width_q,   width_d;    // high cycles of the current pulse
  logic [CNT_W-1:0] pcnt_q,    pcnt_d;     // accepted pulses in this burst
  logic             ovf_q,     ovf_d;      // sticky counter saturation
  logic [WID_W-1:0] lw_hold_q, lw_hold_d;  // width of last accepted pulse
  logic [7:0]       gap_q,     gap_d;      // low cycles since the last fall
  logic             report;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      width_q   <= '0;
      pcnt_q    <= '0;
      ovf_q     <= 1'b0;
      lw_hold_q <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      pcnt_q    <= pcnt_d;
      ovf_q     <= ovf_d;
      lw_hold_q <= lw_hold_d;
      gap_q     <= gap_d;
    end
  end

  // NOTE: every signal driven here gets a hold/default value before the case
  // statement, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    pcnt_d    = pcnt_q;
    ovf_d     = ovf_q;
    lw_hold_d = lw_hold_q;
    gap_d     = gap_q;
    report    = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise && on && armed) begin
          state_d = HIGH;
          width_d = WID_W'(1);
          pcnt_d  = '0;
          ovf_d   = 1'b0;
        end
      end

      HIGH: begin
        if (!on) begin
          // Abort: the partial burst is dropped, outputs are left untouched.
          state_d = IDLE;
        end else if (fall) begin
          gap_d = 8'd1;
          if (width_q >= MIN_W) begin
            if (pcnt_q == CNT_MAX) begin
              ovf_d = 1'b1;
            end else begin
              pcnt_d = pcnt_q + 1'b1;
            end
            lw_hold_d = width_q;
            state_d   = LOW;
          end else begin
            // Glitch: a burst with nothing accepted yet simply evaporates.
            state_d = (pcnt_q != '0) ? LOW : IDLE;
          end
        end else if (s_sync && (width_q != WID_MAX)) begin
          width_d = width_q + 1'b1;
        end
      end

      LOW: begin
        if (!on) begin
          state_d = IDLE;
        end else if (rise) begin
          // A rise in the timeout cycle keeps the burst alive.
          state_d = HIGH;
          width_d = WID_W'(1);
        end else if (gap_q == GAP_END) begin
          report  = 1'b1;
          state_d = IDLE;
        end else if (!s_sync) begin
          gap_d = gap_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result registers: change only in the strobe cycle or on reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      burst_valid <= 1'b0;
      burst_count <= '0;
      last_width  <= '0;
      overflow    <= 1'b0;
    end else begin
      burst_valid <= report;
      if (report) begin
        burst_count <= pcnt_q;
        last_width  <= lw_hold_q;
        overflow    <= ovf_q;
      end
    end
  end

  // The strobe is registered off the LOW->IDLE transition, so busy drops in
  // the same cycle burst_valid is high.
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_pulse_burst_detector.sv
// -----------------------------------------------------------------------------
// tb_pulse_burst_detector
//
// Two detectors share one stimulus: one with the default 8-bit pulse counter
// and one with a 2-bit counter, so saturation and overflow are exercised next
// to the normal case. The stimulus side feeds a run-length reference model
// that predicts each burst report (cycle, accepted pulse count, last width)
// and the per-cycle busy level; a separate monitor compares both detectors
// against those predictions every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pulse_burst_detector;

  localparam int CNT_A = 8;
  localparam int CNT_B = 2;
  localparam int WID_W = 8;
  localparam int GAP   = 16;
  localparam int MIN_W = 2;
  localparam int MAX_A = (1 << CNT_A) - 1;
  localparam int MAX_B = (1 << CNT_B) - 1;
  localparam int WMAX  = (1 << WID_W) - 1;
  localparam int MAXC  = 20000;

  logic clock  = 1'b0;
  logic reset  = 1'b0;
  logic on     = 1'b0;
  logic signal = 1'b0;

  logic [CNT_A-1:0] count_a;
  logic [WID_W-1:0] lw_a;
  logic             bv_a, busy_a, ovf_a;
  logic [CNT_B-1:0] count_b;
  logic [WID_W-1:0] lw_b;
  logic             bv_b, busy_b, ovf_b;

  pulse_burst_detector #(
    .CNT_W(CNT_A), .WID_W(WID_W), .GAP_TIMEOUT(GAP), .MIN_WIDTH(MIN_W)
  ) dut_a (
    .clock(clock), .reset(reset), .on(on), .signal(signal),
    .burst_count(count_a), .last_width(lw_a), .burst_valid(bv_a),
    .busy(busy_a), .overflow(ovf_a)
  );

  pulse_burst_detector #(
    .CNT_W(CNT_B), .WID_W(WID_W), .GAP_TIMEOUT(GAP), .MIN_WIDTH(MIN_W)
  ) dut_b (
    .clock(clock), .reset(reset), .on(on), .signal(signal),
    .burst_count(count_b), .last_width(lw_b), .burst_valid(bv_b),
    .busy(busy_b), .overflow(ovf_b)
  );

  always #5 clock = ~clock;

  int cyc = 0;  // number of posedges seen so far
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks run lengths of the synchronized line.
  // ---------------------------------------------------------------------------
  typedef struct {
    int cyc;  // posedge after which burst_valid is visible
    int n;    // accepted pulses (unsaturated)
    int lw;   // width of last accepted pulse (saturated)
  } rep_t;

  rep_t exp_q[$];
  bit   busy_exp [MAXC];
  bit   sig_hist [MAXC];
  int   held_n  = 0;
  int   held_lw = 0;

  bit m_armed = 1'b0;
  bit m_prev  = 1'b0;
  bit m_pulse = 1'b0;   // inside a pulse that belongs to an open burst
  bit m_open  = 1'b0;   // a burst is in progress
  int m_hi    = 0;      // length of the current high run
  int m_low   = 0;      // low cycles since the last fall, fall cycle included
  int m_n     = 0;
  int m_lw    = 0;
  int first_real = MAXC * 4;

  task automatic model_clear();
    m_armed = 1'b0; m_prev = 1'b0; m_pulse = 1'b0; m_open = 1'b0;
    m_hi = 0; m_low = 0; m_n = 0; m_lw = 0;
    first_real = MAXC * 4;
    exp_q.delete();
    held_n = 0; held_lw = 0;
  endtask

  // v: line level as seen after synchronization, en: enable in the same cycle,
  // p: posedge at which the consequences of this cycle become visible.
  task automatic model_step(input bit v, input bit en, input int p);
    rep_t r;
    if (!m_armed) begin
      if (!v) m_armed = 1'b1;
      m_prev = v;
      return;
    end
    if (!en) begin
      m_pulse = 1'b0;
      m_open  = 1'b0;
    end else if (v && !m_prev) begin
      if (!m_open) m_n = 0;
      m_open  = 1'b1;
      m_pulse = 1'b1;
      m_hi    = 1;
    end else if (v && m_pulse) begin
      m_hi++;
    end else if (!v && m_prev && m_pulse) begin
      m_pulse = 1'b0;
      m_low   = 1;
      if (m_hi >= MIN_W) begin
        m_n++;
        m_lw = (m_hi > WMAX) ? WMAX : m_hi;
      end else if (m_n == 0) begin
        m_open = 1'b0;
      end
    end else if (!v && m_open) begin
      m_low++;
      if (m_low == GAP + 1) begin
        r.cyc = p; r.n = m_n; r.lw = m_lw;
        exp_q.push_back(r);
        m_open = 1'b0;
      end
    end
    m_prev = v;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus: one call per clock cycle, driven on the falling edge.
  // ---------------------------------------------------------------------------
  task automatic tick(input bit v, input bit en, input bit rv = 1'b1);
    int p;
    @(negedge clock);
    p = cyc + 1;
    if (p >= MAXC) begin
      $display("FAIL cycle_budget cycle=%0d limit=%0d", p, MAXC);
      $fatal(1);
    end
    if (!rv && reset) model_clear();
    if (rv && !reset) first_real = p;
    reset = rv;
    signal = v;
    on = en;
    sig_hist[p] = v;
    // The synchronizer delays the line by two cycles; enable is not delayed.
    if (rv && (p - 2 >= first_real)) model_step(sig_hist[p-2], en, p);
    busy_exp[p] = rv && m_open;
  endtask

  task automatic run(input bit v, input int len, input bit en = 1'b1);
    for (int i = 0; i < len; i++) tick(v, en);
  endtask

  task automatic pulse(input int h, input int l);
    run(1'b1, h);
    run(1'b0, l);
  endtask

  task automatic do_reset(input bit v, input int hold);
    for (int i = 0; i < hold; i++) tick(v, 1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    rep_t r;
    bit   exp_bv;
    forever begin
      @(posedge clock);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
      exp_bv = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      if (exp_bv) begin
        r = exp_q.pop_front();
        held_n  = r.n;
        held_lw = r.lw;
      end
      check("valid_a", 32'(bv_a), int'(exp_bv));
      check("valid_b", 32'(bv_b), int'(exp_bv));
      if (cyc < MAXC) begin
        check("busy_a", 32'(busy_a), int'(busy_exp[cyc]));
        check("busy_b", 32'(busy_b), int'(busy_exp[cyc]));
      end
      check("count_a", 32'(count_a), (held_n > MAX_A) ? MAX_A : held_n);
      check("ovf_a",   32'(ovf_a),   int'(held_n > MAX_A));
      check("width_a", 32'(lw_a),    held_lw);
      check("count_b", 32'(count_b), (held_n > MAX_B) ? MAX_B : held_n);
      check("ovf_b",   32'(ovf_b),   int'(held_n > MAX_B));
      check("width_b", 32'(lw_b),    held_lw);
    end
  end

  initial begin
    #(MAXC * 10 + 1000);
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int n, h, l;
    bit en;

    // Reset, then let the line sit low so the detector arms.
    do_reset(1'b0, 3);
    run(1'b0, 5);

    // Four 3-high/3-low pulses, then a long gap: one report, count 4, width 3.
    for (int i = 0; i < 4; i++) pulse(3, 3);
    run(1'b0, 30);

    // Lone glitch: no report. Then widths 4,1,5: count 2, width 5.
    pulse(1, 30);
    pulse(4, 3);
    pulse(1, 3);
    pulse(5, 30);

    // Gap boundary: 15 low cycles keep the burst, 17 split it, and 16 makes
    // the next rise land exactly on the timeout cycle (burst continues).
    pulse(3, 15); pulse(3, 30);
    pulse(3, 17); pulse(3, 30);
    pulse(3, 16); pulse(3, 30);

    // Five accepted pulses saturate the 2-bit counter; next burst clears it.
    for (int i = 0; i < 5; i++) pulse(2, 4);
    run(1'b0, 30);
    pulse(3, 30);

    // Enable dropped inside the 3rd pulse: no report, outputs hold.
    pulse(3, 3);
    pulse(3, 3);
    run(1'b1, 4);
    run(1'b1, 2, 1'b0);
    run(1'b0, 5, 1'b0);
    run(1'b0, 25);
    pulse(3, 3);
    pulse(3, 30);

    // Reset mid-burst with the line held high across the release.
    pulse(3, 3);
    run(1'b1, 2);
    do_reset(1'b1, 3);
    run(1'b1, 10);
    run(1'b0, 4);
    pulse(3, 30);

    // Width measurement saturates at 2^WID_W-1.
    pulse(260, 30);

    // Randomized bursts around the width and gap thresholds.
    for (int b = 0; b < 40; b++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        h  = $urandom_range(1, 6);
        l  = (k == n - 1) ? $urandom_range(10, 40) : $urandom_range(1, 19);
        en = ($urandom_range(0, 15) != 0);
        run(1'b1, h, en);
        run(1'b0, l);
      end
    end
    run(1'b0, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
